dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 74 +++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/DMA arbiter for a shared single-port data memory (define DMEM_ARB_BURST_EN for DMA burst lock)
module dmem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_dout
);
  typedef enum logic [1:0] {IDLE, CPU, DMA} state_t;
  state_t state, stateNext;
  logic rdPend, dmaLock;
  if (BURST_MAX < 1 || BURST_MAX > 15) begin : gBurstRange
    $error("dmem_arbiter: BURST_MAX must be in 1..15");
  end
`ifdef DMEM_ARB_BURST_EN
  localparam logic [3:0] BMAX = 4'(BURST_MAX);
  logic [3:0] bcnt, bcntNext;
  assign dmaLock = (state == DMA) && dma_req && (bcnt < BMAX);
  // Count DMA grants taken while the CPU waits; any break in contention restarts the count
  always_comb bcntNext = (cpu_gnt || !cpu_req || stateNext == IDLE) ? 4'd0 :
                         (dma_gnt && bcnt < BMAX) ? bcnt + 4'd1 : bcnt;
  // Burst counter register
  always_ff @(posedge clk or posedge reset)
    if (reset) bcnt <= 4'd0;
    else bcnt <= bcntNext;
`else
  assign dmaLock = 1'b0;
`endif
  // Arbitration, memory port steering, next owner and read-data return
  always_comb begin
    cpu_gnt    = !reset && cpu_req && !dmaLock;
    dma_gnt    = !reset && dma_req && (!cpu_req || dmaLock);
    cpu_stall  = !reset && cpu_req && !cpu_gnt;
    mem_addr   = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : '0;
    mem_din    = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : '0;
    mem_wen    = (cpu_gnt && cpu_we) || (dma_gnt && dma_we);
    mem_ren    = (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we);
    stateNext  = cpu_gnt ? CPU : dma_gnt ? DMA : IDLE;
    cpu_rvalid = !reset && rdPend && state == CPU;
    dma_rvalid = !reset && rdPend && state == DMA;
    cpu_rdata  = cpu_rvalid ? mem_dout : '0;
    dma_rdata  = dma_rvalid ? mem_dout : '0;
  end
  // Last cycle's grant owner plus whether that access was a read; reset drops any read in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      rdPend <= 1'b0;
    end else begin
      state  <= stateNext;
      rdPend <= mem_ren;
    end
endmodule
